// File: rtl/gpio_port_pkg.sv
// gpio_port_pkg: shared constants for the GPIO port controller.
// Holds the register map, the default reset values and the PRA read mux.
package gpio_port_pkg;

    localparam logic [1:0] ADDR_PRA = 2'd0;
    localparam logic [1:0] ADDR_DDR = 2'd1;
    localparam logic [1:0] ADDR_ICR = 2'd2;
    localparam logic [1:0] ADDR_IMR = 2'd3;

    localparam logic [7:0] DEF_RESET_DDR = 8'h00;
    localparam logic [7:0] DEF_RESET_ORA = 8'hFF;

    // Idle pins read high, so the synchronizer starts at all ones and
    // the first real low level is seen as a falling edge.
    localparam logic [7:0] SYNC_RESET = 8'hFF;

    // Output bits read back the output latch, input bits read the pin.
    function automatic logic [7:0] pra_value(
        input logic [7:0] ddr,
        input logic [7:0] ora,
        input logic [7:0] pins
    );
        return (ddr & ora) | (~ddr & pins);
    endfunction

endpackage

// File: rtl/gpio_edge_detect.sv
// gpio_edge_detect: second-stage pin synchronizer plus sticky falling-edge
// flags (input pins only), cleared by i_clr with set taking priority.
// Ports: clk, reset_n (sync, active low), i_pin, i_ddr, i_clr -> o_sync2, o_flag.
// Compiled only when GPIO_PORT_IRQ_EN is defined.
`ifdef GPIO_PORT_IRQ_EN
module gpio_edge_detect
    import gpio_port_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] i_pin,
    input  logic [7:0] i_ddr,
    input  logic       i_clr,
    output logic [7:0] o_sync2,
    output logic [7:0] o_flag
);

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] r_flag;
    logic [7:0] w_set;

    // sync2 still holds the old level while sync1 already sees the new one.
    assign w_set = r_sync2 & ~r_sync1 & ~i_ddr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= SYNC_RESET;
            r_sync2 <= SYNC_RESET;
            r_flag  <= 8'h00;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            // A clear only drops bits that are not being set this cycle.
            r_flag  <= (i_clr ? 8'h00 : r_flag) | w_set;
        end
    end

    assign o_sync2 = r_sync2;
    assign o_flag  = r_flag;

endmodule
`endif

// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl: 6502 bus port controller for eight GPIO pin cells.
// Ports: clk, reset_n, cs, we, addr, din -> dout; pin_in -> pin_dir, pin_out,
// pin_we; irq_n. Optional edge interrupt logic under GPIO_PORT_IRQ_EN.
module gpio_port_ctrl
    import gpio_port_pkg::*;
#(
    parameter logic [7:0] RESET_DDR = DEF_RESET_DDR,
    parameter logic [7:0] RESET_ORA = DEF_RESET_ORA
)(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] pin_in,
    output logic [7:0] pin_dir,
    output logic [7:0] pin_out,
    output logic       pin_we,
    output logic       irq_n
);

    logic       w_wr;
    logic       w_rd;
    logic [7:0] w_sync2;
    logic [7:0] w_icr;
    logic [7:0] w_imr;
    logic [7:0] w_rdata;

    logic [7:0] r_ora;
    logic [7:0] r_ddr;
    logic [7:0] r_dout;
    logic       r_we_pend;
    logic       r_pin_we;
    logic       r_in_rst;

    assign w_wr = cs & we;
    assign w_rd = cs & ~we;

`ifdef GPIO_PORT_IRQ_EN
    logic [7:0] r_imr;
    logic [7:0] w_flag;
    logic       w_clr;
    logic       r_irq_n;

    assign w_clr = w_rd & (addr == ADDR_ICR);

    gpio_edge_detect u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .i_pin   (pin_in),
        .i_ddr   (r_ddr),
        .i_clr   (w_clr),
        .o_sync2 (w_sync2),
        .o_flag  (w_flag)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_imr   <= 8'h00;
            r_irq_n <= 1'b1;
        end else begin
            if (w_wr && addr == ADDR_IMR)
                r_imr <= din;
            r_irq_n <= ~|(w_flag & r_imr);
        end
    end

    assign w_icr = w_flag;
    assign w_imr = r_imr;
    assign irq_n = r_irq_n;
`else
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= SYNC_RESET;
            r_sync2 <= SYNC_RESET;
        end else begin
            r_sync1 <= pin_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sync2 = r_sync2;
    assign w_icr   = 8'h00;
    assign w_imr   = 8'h00;
    assign irq_n   = 1'b1;
`endif

    always_comb begin
        w_rdata = 8'h00;
        case (addr)
            ADDR_PRA: w_rdata = pra_value(r_ddr, r_ora, w_sync2);
            ADDR_DDR: w_rdata = r_ddr;
            ADDR_ICR: w_rdata = w_icr;
            ADDR_IMR: w_rdata = w_imr;
            default:  w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ora     <= RESET_ORA;
            r_ddr     <= RESET_DDR;
            r_dout    <= 8'h00;
            r_we_pend <= 1'b0;
            r_pin_we  <= 1'b0;
            r_in_rst  <= 1'b1;
        end else begin
            if (w_wr && addr == ADDR_PRA)
                r_ora <= din;
            if (w_wr && addr == ADDR_DDR)
                r_ddr <= din;
            if (w_rd)
                r_dout <= w_rdata;
            // Cells latch ORA once after reset and one cycle after each
            // PRA write, when pin_out has settled.
            r_we_pend <= w_wr & (addr == ADDR_PRA);
            r_pin_we  <= r_we_pend | r_in_rst;
            r_in_rst  <= 1'b0;
        end
    end

    assign dout    = r_dout;
    assign pin_dir = r_ddr;
    assign pin_out = r_ora;
    assign pin_we  = r_pin_we;

endmodule
